wb_port_arbiter: RTL

Arbitrates the single register-file write port between the in-order pipeline writeback (output of the writeback mux) and result returns from the multi-cycle multiply/divide unit (MDU). MDU results queue in a small buffer. Pipeline writes take priority. Queued MDU results drain into idle write slots, or force a pipeline stall when the buffer fills or its head entry starves. The block sits between the writeback stage, the MDU result interface and the register file write port, and it exports a pending-destination mask for the hazard unit.

---
 rtl/rv_wb_pkg.sv | 18 +
 rtl/wb_mdu_fifo.sv | 48 ++++
 rtl/wb_port_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/rv_wb_pkg.sv
// Shared types and defaults for the register-file writeback port arbiter.
package rv_wb_pkg;
  localparam int REG_AW            = 5;
  localparam int XLEN              = 32;
  localparam int DEF_DEPTH         = 2;
  localparam int DEF_STARVE_LIMIT  = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PIPE_PRI = 2'd1,
    ST_DRAIN    = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/wb_mdu_fifo.sv
// MDU result buffer: strict FIFO with occupancy count and pending-destination decode.
module wb_mdu_fifo
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  wb_req_t       push_req,
  input  logic          pop,
  output wb_req_t       head,
  output logic [CW-1:0] count,
  output logic [31:0]   pend_mask
);
  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] off [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_req;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off[i] = PW'(PW'(i) - rd_ptr);
      if (CW'(off[i]) < count) pend_mask[mem[i].rd] = 1'b1;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback has priority, MDU results
// queue and drain into free slots or force a stall when full or starved.
module wb_port_arbiter
  import rv_wb_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              pipe_wr_en_in,
  input  logic [REG_AW-1:0] pipe_rd_addr_in,
  input  logic [XLEN-1:0]   pipe_wb_data_in,
  input  logic              mdu_valid_in,
  output logic              mdu_ready_out,
  input  logic [REG_AW-1:0] mdu_rd_addr_in,
  input  logic [XLEN-1:0]   mdu_data_in,
  output logic              rf_wr_en_out,
  output logic [REG_AW-1:0] rf_rd_addr_out,
  output logic [XLEN-1:0]   rf_wr_data_out,
  output logic              stall_out,
  output logic [31:0]       pend_mask_out
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AGW = $clog2(STARVE_LIMIT + 1);

  wb_state_e      state, state_nxt;
  logic [CW-1:0]  count, cnt_nxt;
  logic [AGW-1:0] age, age_nxt;
  wb_req_t        head, push_req;
  logic           pipe_use, store, pop, empty;

  assign empty         = (count == '0);
  assign mdu_ready_out = (count < CW'(DEPTH));
  assign pipe_use      = pipe_wr_en_in && (pipe_rd_addr_in != '0);
  // x0 results complete the handshake but are never stored.
  assign store         = mdu_valid_in && mdu_ready_out && (mdu_rd_addr_in != '0);
  assign pop           = !pipe_use && !empty;
  assign cnt_nxt       = count + CW'(store) - CW'(pop);
  assign push_req      = '{rd: mdu_rd_addr_in, data: mdu_data_in};

  wb_mdu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .push      (store),
    .push_req  (push_req),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .pend_mask (pend_mask_out)
  );

  always_comb begin
    age_nxt = age;
    if (empty || pop)                  age_nxt = '0;
    else if (age < AGW'(STARVE_LIMIT)) age_nxt = age + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (cnt_nxt != '0) state_nxt = ST_PIPE_PRI;
      ST_PIPE_PRI: begin
        if (cnt_nxt == '0)
          state_nxt = ST_IDLE;
        else if (cnt_nxt == CW'(DEPTH) || age_nxt == AGW'(STARVE_LIMIT))
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN:    if (cnt_nxt == '0) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= ST_IDLE;
      age            <= '0;
      rf_wr_en_out   <= 1'b0;
      rf_rd_addr_out <= '0;
      rf_wr_data_out <= '0;
    end else begin
      state        <= state_nxt;
      age          <= age_nxt;
      rf_wr_en_out <= pipe_use || pop;
      if (pipe_use) begin
        rf_rd_addr_out <= pipe_rd_addr_in;
        rf_wr_data_out <= pipe_wb_data_in;
      end else if (pop) begin
        rf_rd_addr_out <= head.rd;
        rf_wr_data_out <= head.data;
      end else begin
        rf_rd_addr_out <= '0;
        rf_wr_data_out <= '0;
      end
    end
  end

  // State is already a flop, so the stall is registered.
  assign stall_out = (state == ST_DRAIN);
endmodule
